game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
Top-level game sequencer for the flappy-style game. Owns the one-hot game_state bus consumed by the pipe, bird and renderer blocks, and produces a gated per-frame move strobe. Counts score as pipes pass the bird column and holds a session high score. Sits between the button and collision inputs and the pipe datapath.

Parameters:
NUM_PIPES, 4, number of pipe x-positions monitored
PIPE_W, 78, pipe width in pixels (matches pipe datapath)
BIRD_X, 100, fixed bird column in pixels
END_HOLD_FRAMES, 60, frames END_SCREEN ignores flap before accepting restart
SCORE_W, 10, score/high-score width
SCORE_MAX, 999, score saturation value

Ports:
clk  in  1  system clock, single domain
rst  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame
flap_btn  in  1  debounced flap button level
pause_btn  in  1  debounced pause button level
collision  in  1  bird/pipe/ground overlap level
pipe_x  in  NUM_PIPES*32  packed signed pipe left-edge x; pipe i at [32i+31:32i]
game_state  out  4  one-hot: 0001 START_SCREEN, 0010 IN_GAME, 0100 PAUSE, 1000 END_SCREEN
move_tick  out  1  registered frame_tick gated by IN_GAME
score  out  SCORE_W  current score
high_score  out  SCORE_W  best score this session (see Optional Feature)

Behaviour:
- Reset (rst high at clk edge): game_state=START_SCREEN, move_tick=0, score=0, high_score=0, end lockout counter=0, button history regs=0.
- Button press = rising edge: btn & ~btn_q, btn_q registered every cycle. A level held high yields one press.
- All state changes registered; output reflects an event on the next clk edge (1-cycle latency).
- START_SCREEN: flap press -> IN_GAME; score cleared to 0 on this transition. Pause press ignored.
- IN_GAME: collision=1 -> END_SCREEN; else pause press -> PAUSE. Collision has priority over pause. Flap ignored by this block.
- PAUSE: pause press -> IN_GAME. Flap and collision ignored. Score frozen.
- END_SCREEN: on entry lockout counter loads END_HOLD_FRAMES and decrements on each frame_tick to 0. Flap press while counter=0 -> START_SCREEN; earlier presses discarded.
- Illegal state encoding (non-one-hot) -> START_SCREEN next cycle.
- move_tick <= frame_tick && state==IN_GAME; one-cycle pulse, 1-cycle delayed from frame_tick.
- Scoring: on a cycle with frame_tick=1, state=IN_GAME and collision=0, add the count of pipes i with pipe_x[i]+PIPE_W == BIRD_X (32-bit signed compare). Sum saturates at SCORE_MAX. Collision on the same cycle suppresses the increment.
- Pause press coincident with a scoring frame_tick: increment applied and transition to PAUSE, both in the same edge.

Optional Feature:
Macro GAME_HIGH_SCORE_EN.
- Defined: on the IN_GAME->END_SCREEN edge, high_score <= max(high_score, score). The comparison uses the score value including no increment from the collision cycle. Cleared only by rst.
- Not defined: high_score tied to 0, no register inferred.

Decomposition:
- Package game_pkg: state localparams (START_SCREEN, IN_GAME, PAUSE, END_SCREEN), PIPE_SIZE_X=78, CENTRE=210, pipe-spacing constant 180. Shared with the pipe datapath.
- Sub-module btn_edge (clk, rst, level -> press pulse), instantiated for flap and pause.
- Scoring comparator is a generate loop over NUM_PIPES inside this module.

Test Plan:
- Reset then flap rising edge -> game_state 0010 one cycle later, score=0. Holding flap high 10 cycles -> exactly one transition.
- IN_GAME, pipe_x[0]=22 (22+78=100), frame_tick pulse -> score 0->1. Same with collision=1 that cycle -> score stays 0, state -> 1000.
- IN_GAME, pause press -> 0100. 5 frame_ticks -> move_tick stays 0, score unchanged. Pause press -> 0010, and next frame_tick -> move_tick pulses one cycle later.
- END_SCREEN, flap pressed after 59 frame_ticks -> stays 1000. Flap after 60th tick -> 0001. Next flap -> 0010, score cleared.
- Score preset at 998 via play, two pipes at scoring position on one tick -> score=999 (saturated).
- GAME_HIGH_SCORE_EN: game ends at 7 -> high_score=7. Next game ends at 3 -> high_score remains 7. Rst -> 0. Without the macro, high_score is always 0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants and the one-hot game state encoding used by the
// flow controller, pipe datapath, bird and renderer blocks.
package game_pkg;

    typedef enum logic [3:0] {
        START_SCREEN = 4'b0001,
        IN_GAME      = 4'b0010,
        PAUSE        = 4'b0100,
        END_SCREEN   = 4'b1000
    } game_state_t;

    localparam int PIPE_SIZE_X  = 78;
    localparam int CENTRE       = 210;
    localparam int PIPE_SPACING = 180;

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Bundle of the game flow controller's frame, button, collision and pipe
// inputs together with its state/score outputs.
interface game_flow_ctrl_if #(
    parameter int NUM_PIPES = 4,
    parameter int SCORE_W   = 10
);
    logic                     frame_tick;
    logic                     flap_btn;
    logic                     pause_btn;
    logic                     collision;
    logic [NUM_PIPES*32-1:0]  pipe_x;
    logic [3:0]               game_state;
    logic                     move_tick;
    logic [SCORE_W-1:0]       score;
    logic [SCORE_W-1:0]       high_score;

    modport master (
        output frame_tick, flap_btn, pause_btn, collision, pipe_x,
        input  game_state, move_tick, score, high_score
    );

    modport slave (
        input  frame_tick, flap_btn, pause_btn, collision, pipe_x,
        output game_state, move_tick, score, high_score
    );
endinterface

// File: rtl/btn_edge.sv
// Rising-edge detector for a debounced button level: a held level produces a
// single one-cycle press pulse.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic press
);
    logic level_q;

    always_ff @(posedge clk) begin
        if (rst) level_q <= 1'b0;
        else     level_q <= level;
    end

    assign press = level & ~level_q;
endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer: one-hot state, gated move strobe, saturating score and
// session high score (high score enabled by macro GAME_HIGH_SCORE_EN).
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int NUM_PIPES       = 4,
    parameter int PIPE_W          = PIPE_SIZE_X,
    parameter int BIRD_X          = 100,
    parameter int END_HOLD_FRAMES = 60,
    parameter int SCORE_W         = 10,
    parameter int SCORE_MAX       = 999
) (
    input logic             clk,
    input logic             rst,
    game_flow_ctrl_if.slave bus
);
    localparam int CNT_W  = $clog2(NUM_PIPES + 1);
    localparam int LOCK_W = $clog2(END_HOLD_FRAMES + 1);
    localparam logic signed [31:0] PIPE_W_S = 32'(PIPE_W);
    localparam logic signed [31:0] BIRD_X_S = 32'(BIRD_X);

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [CNT_W-1:0]   b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + (SCORE_W+1)'(b);
        if (sum > (SCORE_W+1)'(SCORE_MAX)) return SCORE_W'(SCORE_MAX);
        return sum[SCORE_W-1:0];
    endfunction

    game_state_t        state_q, state_d;
    logic               flap_press, pause_press;
    logic               move_q;
    logic [SCORE_W-1:0] score_q;
    logic [LOCK_W-1:0]  lock_cnt_q;
    logic [NUM_PIPES-1:0] hit;
    logic [CNT_W-1:0]   hit_cnt;
    logic               enter_end;

    btn_edge u_flap_edge  (.clk(clk), .rst(rst), .level(bus.flap_btn),  .press(flap_press));
    btn_edge u_pause_edge (.clk(clk), .rst(rst), .level(bus.pause_btn), .press(pause_press));

    // A pipe scores on the frame its right edge lands exactly on the bird column.
    for (genvar i = 0; i < NUM_PIPES; i++) begin : g_cmp
        logic signed [31:0] px;
        assign px     = bus.pipe_x[32*i +: 32];
        assign hit[i] = (px + PIPE_W_S) == BIRD_X_S;
    end

    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < NUM_PIPES; i++) hit_cnt = hit_cnt + CNT_W'(hit[i]);
    end

    assign enter_end = (state_q == IN_GAME) && bus.collision;

    always_ff @(posedge clk) begin
        if (rst) state_q <= START_SCREEN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            START_SCREEN: if (flap_press) state_d = IN_GAME;
            IN_GAME: begin
                if (bus.collision)    state_d = END_SCREEN;
                else if (pause_press) state_d = PAUSE;
            end
            PAUSE:        if (pause_press) state_d = IN_GAME;
            END_SCREEN:   if (flap_press && lock_cnt_q == '0) state_d = START_SCREEN;
            default:      state_d = START_SCREEN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            move_q     <= 1'b0;
            score_q    <= '0;
            lock_cnt_q <= '0;
        end else begin
            move_q <= bus.frame_tick && (state_q == IN_GAME);

            if (state_q == START_SCREEN && flap_press)
                score_q <= '0;
            else if (state_q == IN_GAME && bus.frame_tick && !bus.collision)
                score_q <= sat_add(score_q, hit_cnt);

            // Restart lockout counts frames, not cycles, from END_SCREEN entry.
            if (enter_end)
                lock_cnt_q <= LOCK_W'(END_HOLD_FRAMES);
            else if (state_q == END_SCREEN && bus.frame_tick && lock_cnt_q != '0)
                lock_cnt_q <= lock_cnt_q - 1'b1;
        end
    end

`ifdef GAME_HIGH_SCORE_EN
    logic [SCORE_W-1:0] high_q;

    // Collision-cycle increments are already suppressed, so score_q is final here.
    always_ff @(posedge clk) begin
        if (rst)                                high_q <= '0;
        else if (enter_end && score_q > high_q) high_q <= score_q;
    end

    assign bus.high_score = high_q;
`else
    assign bus.high_score = '0;
`endif

    assign bus.game_state = state_q;
    assign bus.move_tick  = move_q;
    assign bus.score      = score_q;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with a rule-level reference model checked
// every cycle plus literal expectations at key points of the play sequence.
module tb_game_flow_ctrl;
    localparam int NUM_PIPES = 4;
    localparam int PIPE_W    = 78;
    localparam int BIRD_X    = 100;
    localparam int HOLD      = 60;
    localparam int SCORE_W   = 10;
    localparam int SCORE_MAX = 999;

    logic clk;
    logic rst;
    int   px [NUM_PIPES];
    int   checks   = 0;
    int   failures = 0;

    game_flow_ctrl_if #(.NUM_PIPES(NUM_PIPES), .SCORE_W(SCORE_W)) bus ();

    game_flow_ctrl #(
        .NUM_PIPES(NUM_PIPES), .PIPE_W(PIPE_W), .BIRD_X(BIRD_X),
        .END_HOLD_FRAMES(HOLD), .SCORE_W(SCORE_W), .SCORE_MAX(SCORE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    for (genvar g = 0; g < NUM_PIPES; g++) begin : g_px
        assign bus.pipe_x[32*g +: 32] = px[g];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: modes 0=start 1=playing 2=paused 3=ended
    int mode = 0;
    int m_score = 0;
    int m_hs = 0;
    int end_frames = 0;
    int m_move = 0;
    bit flap_prev = 0;
    bit pause_prev = 0;
    bit armed = 0;

    task automatic model_step();
        bit fp, pp;
        int hits;
        if (rst) begin
            mode = 0; m_score = 0; m_hs = 0; end_frames = 0; m_move = 0;
            flap_prev = 0; pause_prev = 0;
        end else begin
            fp = bus.flap_btn && !flap_prev;
            pp = bus.pause_btn && !pause_prev;
            m_move = (bus.frame_tick && mode == 1) ? 1 : 0;
            case (mode)
                0: if (fp) begin mode = 1; m_score = 0; end
                1: begin
                    if (bus.frame_tick && !bus.collision) begin
                        hits = 0;
                        for (int i = 0; i < NUM_PIPES; i++)
                            if (px[i] + PIPE_W == BIRD_X) hits++;
                        m_score = (m_score + hits > SCORE_MAX) ? SCORE_MAX : m_score + hits;
                    end
                    if (bus.collision) begin
                        if (m_score > m_hs) m_hs = m_score;
                        mode = 3; end_frames = 0;
                    end else if (pp) mode = 2;
                end
                2: if (pp) mode = 1;
                default: begin
                    if (fp && end_frames >= HOLD) mode = 0;
                    if (bus.frame_tick) end_frames++;
                end
            endcase
            flap_prev  = bus.flap_btn;
            pause_prev = bus.pause_btn;
        end
        armed = 1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("cyc_state", int'(bus.game_state), 1 << mode);
            chk("cyc_move", int'(bus.move_tick), m_move);
            chk("cyc_score", int'(bus.score), m_score);
`ifdef GAME_HIGH_SCORE_EN
            chk("cyc_high", int'(bus.high_score), m_hs);
`else
            chk("cyc_high", int'(bus.high_score), 0);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic frame();
        bus.frame_tick = 1'b1; step();
        bus.frame_tick = 1'b0; step();
    endtask

    task automatic press_flap();
        bus.flap_btn = 1'b1; step();
        bus.flap_btn = 1'b0; step();
    endtask

    task automatic press_pause();
        bus.pause_btn = 1'b1; step();
        bus.pause_btn = 1'b0; step();
    endtask

    task automatic collide();
        bus.collision = 1'b1; step();
        bus.collision = 1'b0; step();
    endtask

    task automatic restart();
        repeat (HOLD) frame();
        press_flap();
        press_flap();
    endtask

    task automatic set_px(input int a, input int b, input int c, input int d);
        px[0] = a; px[1] = b; px[2] = c; px[3] = d;
    endtask

    task automatic chk_hs(input string nm, input int val);
`ifdef GAME_HIGH_SCORE_EN
        chk(nm, int'(bus.high_score), val);
`else
        chk(nm, int'(bus.high_score), 0);
`endif
    endtask

    initial begin
        rst = 1'b1;
        bus.frame_tick = 1'b0; bus.flap_btn = 1'b0;
        bus.pause_btn = 1'b0;  bus.collision = 1'b0;
        set_px(500, 500, 500, 500);
        repeat (3) step();
        chk("rst_state", int'(bus.game_state), 1);
        chk("rst_score", int'(bus.score), 0);
        chk("rst_move", int'(bus.move_tick), 0);
        chk_hs("rst_high", 0);
        rst = 1'b0;
        step();

        // Held flap: one press only
        bus.flap_btn = 1'b1; step();
        chk("flap_start", int'(bus.game_state), 2);
        chk("start_score", int'(bus.score), 0);
        repeat (9) step();
        chk("flap_held", int'(bus.game_state), 2);
        bus.flap_btn = 1'b0; step();

        // Scoring pipe 0 at 22, then pipe 1, then a miss and a negative x
        px[0] = 22;
        bus.frame_tick = 1'b1; step();
        chk("score_one", int'(bus.score), 1);
        chk("move_pulse", int'(bus.move_tick), 1);
        bus.frame_tick = 1'b0; step();
        chk("move_low", int'(bus.move_tick), 0);
        set_px(-10, 22, 500, 500); frame();
        chk("score_pipe1", int'(bus.score), 2);
        set_px(-22, 23, 21, 178); frame();
        chk("score_miss", int'(bus.score), 2);

        // Pause freezes everything
        press_pause();
        chk("paused", int'(bus.game_state), 4);
        set_px(22, 22, 22, 22);
        repeat (5) frame();
        chk("pause_score", int'(bus.score), 2);
        press_pause();
        chk("resumed", int'(bus.game_state), 2);
        set_px(500, 500, 500, 500);
        bus.frame_tick = 1'b1; step();
        chk("resume_move", int'(bus.move_tick), 1);
        bus.frame_tick = 1'b0; step();

        // Pause press on a scoring tick: both take effect
        px[0] = 22;
        bus.frame_tick = 1'b1; bus.pause_btn = 1'b1; step();
        chk("pause_tick_score", int'(bus.score), 3);
        chk("pause_tick_state", int'(bus.game_state), 4);
        bus.frame_tick = 1'b0; bus.pause_btn = 1'b0; step();
        press_pause();

        // Collision on a scoring tick suppresses the increment
        bus.frame_tick = 1'b1; bus.collision = 1'b1; step();
        chk("coll_score", int'(bus.score), 3);
        chk("coll_state", int'(bus.game_state), 8);
        bus.frame_tick = 1'b0; bus.collision = 1'b0; step();
        chk_hs("hs_first", 3);

        // Restart lockout
        repeat (HOLD - 1) frame();
        press_flap();
        chk("lock_early", int'(bus.game_state), 8);
        frame();
        press_flap();
        chk("lock_done", int'(bus.game_state), 1);
        press_flap();
        chk("replay", int'(bus.game_state), 2);
        chk("replay_score", int'(bus.score), 0);

        // High score keeps the best game
        set_px(22, 500, 500, 500);
        repeat (7) frame();
        collide();
        chk_hs("hs_seven", 7);
        restart();
        repeat (3) frame();
        chk("score_three", int'(bus.score), 3);
        collide();
        chk_hs("hs_keep", 7);
        restart();

        // Saturation at SCORE_MAX
        set_px(22, 22, 22, 22);
        repeat (249) frame();
        chk("score_996", int'(bus.score), 996);
        set_px(22, 22, 500, 500); frame();
        chk("score_998", int'(bus.score), 998);
        frame();
        chk("score_sat", int'(bus.score), 999);
        set_px(22, 22, 22, 22); frame();
        chk("score_sat_hold", int'(bus.score), 999);
        collide();
        chk_hs("hs_max", 999);

        rst = 1'b1; step();
        chk("rst2_state", int'(bus.game_state), 1);
        chk("rst2_score", int'(bus.score), 0);
        chk_hs("rst2_high", 0);
        rst = 1'b0;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
